// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier for MIPS mult/multu.
// A WIDTH-bit ripple-carry chain of full_adder cells adds the multiplicand
// into the accumulator's upper half once per clock. After WIDTH iterations
// the product is written to hi/lo, and done pulses for one cycle.
// Optional feature macro MULT_SIGNED_EN: when it is defined, is_signed selects
// signed multiplication (operand magnitudes plus a final negate). When it is
// undefined, every operation is unsigned and is_signed is ignored.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic               capture;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [WIDTH:0]     upper_next;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fin;

  // A new operation is accepted whenever the unit is not mid-run (IDLE or DONE).
  assign capture = start && (state_q != S_RUN);

`ifdef MULT_SIGNED_EN
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    // The most negative value maps to 2^(WIDTH-1) as an unsigned magnitude.
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  logic neg_q;

  assign mag_a_in = is_signed ? abs_val(a) : a;
  assign mag_b_in = is_signed ? abs_val(b) : b;

  // Latch the product sign with the operands; it is applied only at completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
    end else if (capture) begin
      neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end

  // Negating a zero product yields zero again, so no sign artefact appears.
  assign prod_fin = neg_q ? negate(acc_step) : acc_step;
`else
  logic is_signed_unused;

  assign is_signed_unused = is_signed;
  assign mag_a_in         = a;
  assign mag_b_in         = b;
  assign prod_fin         = acc_step;
`endif

  // Adder chain: upper half of the accumulator plus the multiplicand.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a_i (acc_q[WIDTH+i]),
      .b_i (mag_a_q[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // The carry-out becomes the new top bit once the (2W+1)-bit sum shifts right.
  assign upper_next = acc_q[0] ? {carry[WIDTH], sum} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign acc_step   = {upper_next, acc_q[WIDTH-1:1]};

  // Next-state logic: operand capture, one iteration per RUN cycle, result write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (capture) begin
          state_d = S_RUN;
          mag_a_d = mag_a_in;
          acc_d   = {{WIDTH{1'b0}}, mag_b_in};
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = prod_fin;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and result registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit (WIDTH=32). It uses a table of directed multiply
// vectors, then hand-written sequences for start-while-busy, start in the
// DONE cycle, and an asynchronous reset in the middle of an operation.
// Expected values for signed vectors depend on MULT_SIGNED_EN.

module tb_mult_unit;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start an operation and wait (bounded) for done.
  // lat = cycle index at which done is seen, with the start cycle as 0.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        output int lat, output int bcnt);
    a = va; b = vb; is_signed = vs; start = 1'b1;
    tick();
    start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, cyc, pulses;

    vecs[0] = '{"u_3x5",        32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{"u_max",        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"u_zero_a",     32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{"u_7xfffffffd", 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'h0000_0006, 32'hFFFF_FFEB};
    vecs[4] = '{"u_2p16sq",     32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
`ifdef MULT_SIGNED_EN
    vecs[5] = '{"s_m2x3",       32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[6] = '{"s_m1xm1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[7] = '{"s_minx2",      32'h8000_0000, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
`else
    vecs[5] = '{"s_m2x3",       32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[6] = '{"s_m1xm1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7] = '{"s_minx2",      32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'h0000_0000};
`endif
    vecs[8] = '{"s_zeroxm1",    32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{"s_minxmin",    32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};

    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    tick(); tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcnt);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
      check({vecs[i].name, "_busycyc"}, 64'(bcnt), 64'd32);
      check({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      tick();
      check({vecs[i].name, "_done_1cyc"}, {63'd0, done}, 64'd0);
    end

    // Start while busy is ignored; operands changing after capture have no effect.
    a = 32'd7; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 10) begin a = 32'd9; b = 32'd9; start = 1'b1; end
      tick();
      start = 1'b0;
      cyc++;
    end
    check("busy_start_latency", 64'(cyc), 64'd33);
    check("busy_start_lo", {32'd0, lo}, 64'd42);
    check("busy_start_hi", {32'd0, hi}, 64'd0);

    // Start accepted in the DONE cycle.
    a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_done_drop", {63'd0, done}, 64'd0);
    check("done_start_busy", {63'd0, busy}, 64'd1);
    check("done_start_hold_lo", {32'd0, lo}, 64'd42);
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("done_start_latency", 64'(cyc), 64'd33);
    check("done_start_lo", {32'd0, lo}, 64'd4);
    tick();

    // Asynchronous reset in the middle of a run.
    a = 32'd100; b = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    check("midrun_busy_before", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrun_rst_busy", {63'd0, busy}, 64'd0);
    check("midrun_rst_hilo", {hi, lo}, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("midrun_no_done", 64'(pulses), 64'd0);
    run_op(32'd100, 32'd100, 1'b0, lat, bcnt);
    check("after_rst_latency", 64'(lat), 64'd33);
    check("after_rst_lo", {32'd0, lo}, 64'd10000);
    check("after_rst_hi", {32'd0, hi}, 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
